// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: opcodes, fetch state encoding, widths and reset vector.
package mips_pkg;

  localparam int XLEN   = 32;
  localparam int JIDX_W = 26;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_VALID = 1'b1
  } fetch_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Next-PC selection for the fetch stage: jump beats taken branch beats sequential.
module npc_calc
  import mips_pkg::*;
(
  input  logic [XLEN-1:0]   pc_plus4,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_imm,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_target,
  output logic [XLEN-1:0]   npc
);

  always_comb begin
    npc = pc_plus4;
    if (jump) begin
      npc = {pc_plus4[XLEN-1:XLEN-4], jump_target, 2'b00};
    end else if (branch_taken) begin
      npc = pc_plus4 + (branch_imm << 2);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches over a ready handshake and
// presents one registered instruction at a time to decode.
//
//   state   | meaning
//   S_FETCH | request outstanding at pc_q, waiting for imem_ready
//   S_VALID | instr_o presented, waiting for downstream to consume
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [XLEN-1:0]   imem_rdata,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  logic [XLEN-1:0]   branch_imm_i,
  input  logic              jump_i,
  input  logic [JIDX_W-1:0] jump_target_i,
  output logic [XLEN-1:0]   instr_o,
  output logic              instr_valid_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   pc_plus4_o,
  output logic [XLEN-1:0]   fetch_count_o
);

  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = word_align(RESET_PC);

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] npc;

  // Gating with rst_n lets the request drop the instant reset asserts.
  assign imem_req  = rst_n && (state_q == S_FETCH);
  assign imem_addr = pc_q;

  npc_calc u_npc_calc (
    .pc_plus4     (pc_plus4_o),
    .branch_taken (branch_taken_i),
    .branch_imm   (branch_imm_i),
    .jump         (jump_i),
    .jump_target  (jump_target_i),
    .npc          (npc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC_ALIGNED;
      instr_o       <= '0;
      instr_valid_o <= 1'b0;
      pc_o          <= '0;
      pc_plus4_o    <= 32'd4;
      fetch_count_o <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ready) begin
            instr_o       <= imem_rdata;
            pc_o          <= pc_q;
            pc_plus4_o    <= pc_q + 32'd4;
            instr_valid_o <= 1'b1;
            state_q       <= S_VALID;
          end
        end
        S_VALID: begin
          if (!stall_i) begin
            pc_q          <= npc;
            fetch_count_o <= fetch_count_o + 32'd1;
            instr_valid_o <= 1'b0;
            state_q       <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed redirect/stall/reset cases, then random traffic.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        stall_i = 1'b1;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_imm_i = '0;
  logic        jump_i = 1'b0;
  logic [25:0] jump_target_i = '0;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [31:0] fetch_count_o;

  int checks = 0;
  int errors = 0;
  int hold_low = 0;
  int ready_pct = 100;
  int consumes = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  logic        m_fetching;
  logic [31:0] m_addr;
  logic [31:0] m_count;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .stall_i        (stall_i),
    .branch_taken_i (branch_taken_i),
    .branch_imm_i   (branch_imm_i),
    .jump_i         (jump_i),
    .jump_target_i  (jump_target_i),
    .instr_o        (instr_o),
    .instr_valid_o  (instr_valid_o),
    .pc_o           (pc_o),
    .pc_plus4_o     (pc_plus4_o),
    .fetch_count_o  (fetch_count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:16] ^ a[15:0], a[15:0]} ^ 32'h5A5A_3C3C;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, want);
    end
  endtask

  // Memory responder: optional forced wait cycles, otherwise random readiness.
  always @(posedge clk) begin
    #1;
    if (imem_req && hold_low > 0) begin
      imem_ready = 1'b0;
      hold_low--;
    end else begin
      imem_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor: reference model of the fetch stream, compared on every negedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_fetching = 1'b1;
      m_addr     = 32'h0000_0000;
      m_count    = '0;
      exp_q.delete();
    end else if (m_fetching) begin
      check("req_in_fetch", imem_req, 1);
      check("fetch_addr", imem_addr, m_addr);
      check("valid_in_fetch", instr_valid_o, 0);
      if (imem_ready) begin
        exp_q.push_back('{pc: m_addr, instr: mem_word(m_addr)});
        m_fetching = 1'b0;
      end
    end else begin
      check("req_in_valid", imem_req, 0);
      check("valid", instr_valid_o, 1);
      check("queue_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_t e;
        logic [31:0] p4;
        e  = exp_q[0];
        p4 = e.pc + 32'd4;
        check("instr", instr_o, e.instr);
        check("pc", pc_o, e.pc);
        check("pc_plus4", pc_plus4_o, p4);
        check("count", fetch_count_o, m_count);
        if (!stall_i) begin
          if (jump_i)              m_addr = {p4[31:28], jump_target_i, 2'b00};
          else if (branch_taken_i) m_addr = p4 + branch_imm_i * 4;
          else                     m_addr = p4;
          m_count++;
          consumes++;
          void'(exp_q.pop_front());
          m_fetching = 1'b1;
        end
      end
    end
  end

  // Called at posedge+1; waits for a presented instruction, stalls, then consumes once.
  task automatic consume(input int stall_n, input logic jmp, input logic [25:0] tgt,
                         input logic br, input logic [31:0] imm, input int hold);
    int t = 0;
    while (!instr_valid_o && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("valid_wait", instr_valid_o, 1);
    stall_i = 1'b1;
    repeat (stall_n) begin
      jump_i = 1'b1;
      jump_target_i = 26'($urandom);
      branch_taken_i = 1'b1;
      branch_imm_i = $urandom;
      @(posedge clk); #1;
    end
    stall_i = 1'b0;
    jump_i = jmp;
    jump_target_i = tgt;
    branch_taken_i = br;
    branch_imm_i = imm;
    hold_low = hold;
    @(posedge clk); #1;
    stall_i = 1'b1;
    jump_i = 1'b0;
    branch_taken_i = 1'b0;
  endtask

  initial begin
    logic [31:0] imm;
    repeat (2) @(posedge clk);
    #2;
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid_o, 0);
    check("rst_instr", instr_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_pc4", pc_plus4_o, 4);
    check("rst_count", fetch_count_o, 0);
    check("rst_addr", imem_addr, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    consume(0, 0, '0, 0, '0, 0);
    check("seq_addr4", imem_addr, 32'h4);
    consume(0, 0, '0, 0, '0, 3);
    check("wait_addr8", imem_addr, 32'h8);
    consume(4, 0, '0, 0, '0, 0);
    check("after_stall_addr", imem_addr, 32'hC);
    check("count3", fetch_count_o, 3);
    consume(0, 1, 26'h40, 0, '0, 0);
    check("jump_0x100", imem_addr, 32'h100);
    consume(0, 0, '0, 1, 32'hFFFF_FFFE, 0);
    check("branch_back", imem_addr, 32'h0FC);
    consume(0, 0, '0, 1, 32'h03FF_FFD0, 0);
    check("branch_fwd", imem_addr, 32'h1000_0040);
    consume(0, 1, 26'h00_0010, 0, '0, 0);
    check("jump_target", imem_addr, 32'h1000_0040);
    consume(0, 1, 26'h00_0010, 1, 32'h0000_0005, 0);
    check("jump_priority", imem_addr, 32'h1000_0040);
    while (!instr_valid_o) begin @(posedge clk); #1; end
    imm = (32'hFFFF_FFFC - (pc_o + 32'd4)) >> 2;
    consume(0, 0, '0, 1, imm, 0);
    check("branch_top", imem_addr, 32'hFFFF_FFFC);
    consume(0, 0, '0, 0, '0, 0);
    check("pc_wrap", imem_addr, 32'h0);
    consume(0, 0, '0, 0, '0, 1000);

    // Abort an outstanding request with reset; the late ready must not be captured.
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_req", imem_req, 0);
    check("abort_valid", instr_valid_o, 0);
    check("abort_pc4", pc_plus4_o, 4);
    check("abort_count", fetch_count_o, 0);
    check("abort_addr", imem_addr, 0);
    hold_low = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_count", fetch_count_o, 0);
    check("post_rst_pc", pc_o, 0);
    check("post_rst_instr", instr_o, mem_word(32'h0));

    ready_pct = 70;
    for (int i = 0; i < 2000; i++) begin
      stall_i = ($urandom_range(0, 3) == 0);
      jump_i = ($urandom_range(0, 5) == 0);
      branch_taken_i = ($urandom_range(0, 2) == 0);
      jump_target_i = 26'($urandom);
      if ($urandom_range(0, 7) == 0) branch_imm_i = $urandom;
      else branch_imm_i = 32'($urandom_range(0, 63)) - 32'd32;
      @(posedge clk); #1;
    end
    stall_i = 1'b1;
    repeat (4) @(posedge clk);
    check("random_consumes", consumes > 300, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
